// File: rtl/serial_pkg.sv
// serial_pkg: shared link parameters and receiver state encoding for the serial link.
package serial_pkg;
    localparam int SER_WIDTH = 32;
    localparam int SER_CNT_W = 6;
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} rx_state_t;
endpackage

// File: rtl/serial_edge_det.sv
// serial_edge_det: registers a level and emits one-cycle rise/fall pulses against its history.
module serial_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic d_q;
    always_ff @(posedge clk_i) d_q <= rst_i ? 1'b0 : d_i;
    assign rise_o = d_i & ~d_q;
    assign fall_o = ~d_i & d_q;
endmodule

// File: rtl/serial_receiver.sv
// serial_receiver: MSB-first deserializer with valid/read handshake, framing and overrun flags.
// Defining SERIAL_RX_PARITY_EN appends a trailing even-parity bit to each frame.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int CNT_W = SER_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Din,
    input  logic             DinStrobe,
    input  logic             FrameActive,
    input  logic             DataRead,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataValid,
    output logic             RxDone,
    output logic             RxBusy,
    output logic             FrameErr,
    output logic             Overrun,
    output logic             ParityErr
);
`ifdef SERIAL_RX_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    rx_state_t state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d, word;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic valid_q, valid_d, done_q, done_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic fa_rise, fa_fall, last, complete;

    serial_edge_det u_edge (
        .clk_i (Clk),
        .rst_i (Reset),
        .d_i   (FrameActive),
        .rise_o(fa_rise),
        .fall_o(fa_fall)
    );

    // SHIFT and WAIT_END are only entered with FrameActive high, so a fall pulse means it dropped.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        complete = 1'b0;
        word     = {sr_q[FRAME_BITS-2:0], Din};
        last     = cnt_q == CNT_W'(FRAME_BITS - 1);
        case (state_q)
            IDLE: if (fa_rise) begin
                state_d = SHIFT;
                sr_d    = DinStrobe ? word : sr_q;
                cnt_d   = DinStrobe ? CNT_W'(1) : '0;
            end
            SHIFT: if (fa_fall) begin
                ferr_d  = 1'b1;
                state_d = IDLE;
            end else if (DinStrobe) begin
                sr_d  = word;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    complete = 1'b1;
                    done_d   = 1'b1;
                    data_d   = word[FRAME_BITS-1 -: WIDTH];
                    state_d  = WAIT_END;
                end
            end
            WAIT_END: if (fa_fall) state_d = IDLE;
                      else if (DinStrobe) ferr_d = 1'b1;
            default: state_d = IDLE;
        endcase
        valid_d = complete | (valid_q & ~DataRead);
        ovr_d   = (complete & valid_q & ~DataRead) | (ovr_q & ~DataRead);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic par_q, par_d;
    // Even parity over data plus parity bit is zero when the frame is clean.
    assign par_d = complete ? ^word : par_q;
    always_ff @(posedge Clk) par_q <= Reset ? 1'b0 : par_d;
    assign ParityErr = par_q;
`else
    assign ParityErr = 1'b0;
`endif

    assign DataOut   = data_q;
    assign DataValid = valid_q;
    assign RxDone    = done_q;
    assign RxBusy    = state_q != IDLE;
    assign FrameErr  = ferr_q;
    assign Overrun   = ovr_q;
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed scoreboard bench for serial_receiver (honours SERIAL_RX_PARITY_EN).
module tb_serial_receiver;
`ifdef SERIAL_RX_PARITY_EN
    localparam int FB = 33;
`else
    localparam int FB = 32;
`endif
    logic Clk = 1'b0, Reset = 1'b0, Din = 1'b0, DinStrobe = 1'b0, FrameActive = 1'b0, DataRead = 1'b0;
    logic [31:0] DataOut;
    logic DataValid, RxDone, RxBusy, FrameErr, Overrun, ParityErr;
    logic [31:0] exp_q[$];
    int pass_n = 0, fail_n = 0, total_n = 0;

    serial_receiver dut (
        .Clk(Clk), .Reset(Reset), .Din(Din), .DinStrobe(DinStrobe), .FrameActive(FrameActive),
        .DataRead(DataRead), .DataOut(DataOut), .DataValid(DataValid), .RxDone(RxDone),
        .RxBusy(RxBusy), .FrameErr(FrameErr), .Overrun(Overrun), .ParityErr(ParityErr)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b);
        Din = b;
        DinStrobe = 1'b1;
        tick();
        DinStrobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        FrameActive = 1'b0;
        DinStrobe = 1'b0;
        DataRead = 1'b0;
        tick();
        Reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 31; i > 31 - n; i--) strobe(w[i]);
    endtask

    task automatic read_word();
        DataRead = 1'b1;
        tick();
        DataRead = 1'b0;
    endtask

    // Sends a whole frame; rd asserts DataRead in the completion cycle, same puts bit 0 on the rising edge.
    task automatic full_frame(input logic [31:0] w, input logic p, input logic rd, input bit same);
        logic [32:0] f;
        logic exp_perr;
        f = {w, p};
        exp_perr = (FB == 33) ? (^w ^ p) : 1'b0;
        exp_q.push_back(w);
        FrameActive = 1'b1;
        if (!same) tick();
        for (int i = 32; i > 33 - FB; i--) strobe(f[i]);
        Din = f[33-FB];
        DinStrobe = 1'b1;
        DataRead = rd;
        tick();
        DinStrobe = 1'b0;
        DataRead = 1'b0;
        chk("done_pulse", {31'd0, RxDone}, 32'd1);
        if (RxDone) chk("sb_data", DataOut, exp_q.pop_front());
        chk("valid_on_done", {31'd0, DataValid}, 32'd1);
        chk("parity_err", {31'd0, ParityErr}, {31'd0, exp_perr});
        tick();
        chk("done_one_cycle", {31'd0, RxDone}, 32'd0);
    endtask

    task automatic end_frame();
        FrameActive = 1'b0;
        tick();
        chk("busy_after_fall", {31'd0, RxBusy}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_dataout", DataOut, 32'd0);
        chk("rst_flags", {25'd0, DataValid, RxDone, RxBusy, FrameErr, Overrun, ParityErr, 1'b0}, 32'd0);

        strobe(1'b1);
        chk("idle_strobe_ignored", {31'd0, RxBusy}, 32'd0);
        FrameActive = 1'b1;
        tick();
        chk("busy_after_rise", {31'd0, RxBusy}, 32'd1);
        FrameActive = 1'b0;
        tick();
        chk("busy_cleared", {31'd0, RxBusy}, 32'd0);
        do_reset();

        full_frame(32'hA5A5_0F0F, ^32'hA5A5_0F0F, 1'b0, 1'b0);
        Din = 1'b1;
        DinStrobe = 1'b1;
        tick();
        DinStrobe = 1'b0;
        chk("extra_strobe_ferr", {31'd0, FrameErr}, 32'd1);
        chk("extra_strobe_keep", DataOut, 32'hA5A5_0F0F);
        tick();
        chk("ferr_one_cycle", {31'd0, FrameErr}, 32'd0);
        end_frame();

        do_reset();
        FrameActive = 1'b1;
        tick();
        send_bits(32'h1234_5678, 20);
        FrameActive = 1'b0;
        tick();
        chk("short_ferr", {31'd0, FrameErr}, 32'd1);
        chk("short_valid", {31'd0, DataValid}, 32'd0);
        chk("short_dataout", DataOut, 32'd0);
        chk("short_idle", {31'd0, RxBusy}, 32'd0);
        tick();
        chk("short_ferr_clear", {31'd0, FrameErr}, 32'd0);
        full_frame(32'h1234_5678, ^32'h1234_5678, 1'b0, 1'b0);
        end_frame();
        read_word();
        chk("read_clears_valid", {31'd0, DataValid}, 32'd0);
        chk("read_holds_data", DataOut, 32'h1234_5678);

        full_frame(32'h0000_0001, 1'b1, 1'b0, 1'b0);
        end_frame();
        chk("no_overrun_yet", {31'd0, Overrun}, 32'd0);
        full_frame(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        end_frame();
        chk("overrun_set", {31'd0, Overrun}, 32'd1);
        read_word();
        chk("ovr_read_valid", {31'd0, DataValid}, 32'd0);
        chk("ovr_read_clear", {31'd0, Overrun}, 32'd0);

        full_frame(32'hCAFE_F00D, ^32'hCAFE_F00D, 1'b0, 1'b0);
        end_frame();
        full_frame(32'h0BAD_C0DE, ^32'h0BAD_C0DE, 1'b1, 1'b0);
        chk("coinc_valid", {31'd0, DataValid}, 32'd1);
        chk("coinc_data", DataOut, 32'h0BAD_C0DE);
        chk("coinc_no_ovr", {31'd0, Overrun}, 32'd0);
        end_frame();

        FrameActive = 1'b1;
        tick();
        send_bits(32'hDEAD_BEEF, 10);
        Reset = 1'b1;
        FrameActive = 1'b0;
        tick();
        Reset = 1'b0;
        exp_q.delete();
        chk("midrst_dataout", DataOut, 32'd0);
        chk("midrst_flags", {26'd0, DataValid, RxDone, RxBusy, FrameErr, Overrun, ParityErr}, 32'd0);
        tick();
        chk("midrst_no_done", {31'd0, RxDone}, 32'd0);
        full_frame(32'hDEAD_BEEF, ^32'hDEAD_BEEF, 1'b0, 1'b1);
        end_frame();
        read_word();

`ifdef SERIAL_RX_PARITY_EN
        full_frame(32'h0000_0001, 1'b0, 1'b0, 1'b0);
        chk("par_bad_flag", {31'd0, ParityErr}, 32'd1);
        chk("par_bad_data", DataOut, 32'h0000_0001);
        end_frame();
        full_frame(32'h0000_0001, 1'b1, 1'b1, 1'b0);
        chk("par_good_flag", {31'd0, ParityErr}, 32'd0);
        end_frame();
`endif

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
